// File: rtl/ysyx_22040750_booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, full 2*XLEN-bit product.
// Optional YSYX_22040750_MUL_EARLY_EXIT_EN ends BUSY once every remaining digit is zero.
module ysyx_22040750_booth_mul_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN/2+2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [XLEN-1:0] mul1,
  input  logic [XLEN-1:0] mul2,
  input  logic [1:0]      sext_flag,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  localparam int ACC_W = 2*XLEN+4;
  localparam int MPL_W = XLEN+3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN/2);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  logic [MPL_W-1:0]   r_mplr;
  logic [ACC_W-1:0]   r_mcand;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mul_ready;
  logic               r_res_valid;

  logic               w_s1;
  logic               w_s2;
  logic [ACC_W-1:0]   w_pp;
  logic               w_neg;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_acc_sum;
  logic [MPL_W-1:0]   w_mplr_shr;
  logic [ACC_W-1:0]   w_mcand_shl;
  logic               w_last;

  assign w_s1 = mul1[XLEN-1] & sext_flag[1];
  assign w_s2 = mul2[XLEN-1] & sext_flag[0];

  // Booth digit from the low triple: magnitude 0/1/2 times multiplicand, plus sign
  always_comb begin
    w_pp  = '0;
    w_neg = 1'b0;
    case (r_mplr[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = {r_mcand[ACC_W-2:0], 1'b0};
      3'b100: begin
        w_pp  = {r_mcand[ACC_W-2:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_pp  = r_mcand;
        w_neg = 1'b1;
      end
      default: begin
        w_pp  = '0;
        w_neg = 1'b0;
      end
    endcase
  end

  // Subtraction folds into the same adder as invert plus carry-in
  assign w_addend    = w_neg ? ~w_pp : w_pp;
  assign w_acc_sum   = r_acc + w_addend + {{(ACC_W-1){1'b0}}, w_neg};
  assign w_mplr_shr  = {{2{r_mplr[MPL_W-1]}}, r_mplr[MPL_W-1:2]};
  assign w_mcand_shl = {r_mcand[ACC_W-3:0], 2'b00};

`ifdef YSYX_22040750_MUL_EARLY_EXIT_EN
  logic w_rest_zero;
  // A uniform remaining multiplier recodes to all-zero digits
  assign w_rest_zero = (&w_mplr_shr) | ~(|w_mplr_shr);
  assign w_last      = (r_cnt == LAST_CNT) | w_rest_zero;
`else
  assign w_last      = (r_cnt == LAST_CNT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mplr      <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mul_ready <= 1'b1;
      r_res_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mul_ready <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mul_valid && r_mul_ready) begin
            r_state     <= S_BUSY;
            r_mplr      <= {{2{w_s2}}, mul2, 1'b0};
            r_mcand     <= {{(XLEN+4){w_s1}}, mul1};
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mul_ready <= 1'b0;
          end
        end
        S_BUSY: begin
          r_acc   <= w_acc_sum;
          r_mplr  <= w_mplr_shr;
          r_mcand <= w_mcand_shl;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_mul_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
          r_mul_ready <= 1'b1;
        end
      endcase
    end
  end

  assign mul_ready = r_mul_ready;
  assign res_valid = r_res_valid;
  assign res_hi    = r_acc[2*XLEN-1:XLEN];
  assign res_lo    = r_acc[XLEN-1:0];

endmodule

// File: tb/tb_ysyx_22040750_booth_mul_iter.sv
// Self-checking bench for ysyx_22040750_booth_mul_iter: directed corner cases plus
// randomized operands compared with a plain-arithmetic product model.
module tb_ysyx_22040750_booth_mul_iter;

  localparam int XLEN = 64;
  localparam int W2   = 2*XLEN;
  localparam int LAT  = XLEN/2+1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            mul_valid = 1'b0;
  logic            mul_ready;
  logic [XLEN-1:0] mul1 = '0;
  logic [XLEN-1:0] mul2 = '0;
  logic [1:0]      sext_flag = 2'b00;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040750_booth_mul_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .mul_valid (mul_valid),
    .mul_ready (mul_ready),
    .mul1      (mul1),
    .mul2      (mul2),
    .sext_flag (sext_flag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W2-1:0] obs, input logic [W2-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Product modulo 2^(2*XLEN) of the operands extended per their signedness
  function automatic logic [W2-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                            input logic [1:0] sf);
    logic [W2-1:0] ea;
    logic [W2-1:0] eb;
    ea = sf[1] ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = sf[0] ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [XLEN-1:0] rand_operand();
    logic [XLEN-1:0] v;
    v = '0;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(XLEN-1){1'b0}}};
      3: v = XLEN'($urandom_range(0, 15));
      default: begin
        for (int k = 0; k < (XLEN+31)/32; k++) v = (v << 32) | XLEN'($urandom());
      end
    endcase
    return v;
  endfunction

  task automatic do_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [1:0] sf,
                       input logic rr, output logic [W2-1:0] prod, output int lat);
    int n;
    n = 0;
    while (!mul_ready && n < 100) begin
      tick();
      n++;
    end
    check("wait_ready", W2'(mul_ready), W2'(1));
    mul1 = a;
    mul2 = b;
    sext_flag = sf;
    res_ready = rr;
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < LAT+10) begin
      tick();
      lat++;
    end
    check("res_valid_seen", W2'(res_valid), W2'(1));
    prod = {res_hi, res_lo};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, W2'(mul_ready), W2'(1));
    check({tag, "_valid"}, W2'(res_valid), W2'(0));
    check({tag, "_hi"},    W2'(res_hi),    W2'(0));
    check({tag, "_lo"},    W2'(res_lo),    W2'(0));
  endtask

  logic [W2-1:0]   p;
  logic [W2-1:0]   held;
  logic [W2-1:0]   exp_p;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [1:0]      sf;
  int              lat;
  int              n_rv;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    do_op('1, '1, 2'b00, 1'b1, p, lat);
    $display("op uu ones -> %h lat=%0d", p, lat);
    check("uu_ones", p, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
`ifndef YSYX_22040750_MUL_EARLY_EXIT_EN
    check("uu_lat", W2'(lat), W2'(LAT));
`endif

    do_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 2'b11, 1'b1, p, lat);
    $display("op ss -3*7 -> %h", p);
    check("ss_m3x7", p, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB});

    do_op('1, '1, 2'b10, 1'b1, p, lat);
    $display("op su -1*max -> %h", p);
    check("su_m1xmax", p, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001});

    do_op('1, '1, 2'b01, 1'b1, p, lat);
    $display("op us max*-1 -> %h", p);
    check("us_maxxm1", p, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001});

    // Back-pressure with a competing request that must be ignored
    a = 64'h0000_0000_075B_CD15;
    b = 64'hFFFF_FFFF_FFFF_FFFB;
    do_op(a, b, 2'b11, 1'b0, p, lat);
    $display("op bp ss -> %h", p);
    check("bp_prod", p, ref_mul(a, b, 2'b11));
    held = {res_hi, res_lo};
    mul1 = 64'd5;
    mul2 = 64'd5;
    mul_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid",  W2'(res_valid), W2'(1));
      check("bp_stable", {res_hi, res_lo}, held);
      check("bp_ready",  W2'(mul_ready), W2'(0));
    end
    mul_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    check("bp_rel_valid", W2'(res_valid), W2'(0));
    check("bp_rel_ready", W2'(mul_ready), W2'(1));

    // Flush during BUSY cycle 5
    mul1 = 64'd1000;
    mul2 = 64'd1000;
    sext_flag = 2'b00;
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", W2'(res_valid), W2'(0));
    check("flush_ready", W2'(mul_ready), W2'(1));
    check("flush_lo",    W2'(res_lo),    W2'(0));
    n_rv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) n_rv++;
    end
    check("flush_no_valid", W2'(n_rv), W2'(0));

    // Flush and request together: request dropped
    mul1 = 64'd3;
    mul2 = 64'd3;
    mul_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mul_valid = 1'b0;
    check("flush_drop", W2'(mul_ready), W2'(1));

    do_op(64'd6, 64'd7, 2'b00, 1'b1, p, lat);
    $display("op 6*7 -> %h", p);
    check("after_flush_6x7", p, W2'(42));

    do_op(64'd3, 64'd4, 2'b00, 1'b0, p, lat);
    check("done_prod_3x4", p, W2'(12));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    res_ready = 1'b1;
    check("flush_done_valid", W2'(res_valid), W2'(0));
    check("flush_done_lo",    W2'(res_lo),    W2'(0));
    check("flush_done_ready", W2'(mul_ready), W2'(1));

    // Reset during BUSY
    mul1 = 64'd9;
    mul2 = 64'd9;
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_busy");
    n_rv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) n_rv++;
    end
    check("rst_busy_no_valid", W2'(n_rv), W2'(0));

    // Reset during DONE
    do_op(64'd11, 64'd13, 2'b00, 1'b0, p, lat);
    check("done_prod_11x13", p, W2'(143));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    check_reset_outputs("rst_done");

    // Multiplier of 1: eligible for early termination
    a = 64'hDEAD_BEEF_0123_4567;
    do_op(a, 64'd1, 2'b11, 1'b1, p, lat);
    $display("op ss a*1 -> %h lat=%0d", p, lat);
    check("x1_prod", p, ref_mul(a, 64'd1, 2'b11));
`ifdef YSYX_22040750_MUL_EARLY_EXIT_EN
    check("x1_early", W2'(lat < LAT), W2'(1));
`else
    check("x1_lat", W2'(lat), W2'(LAT));
`endif

    for (int i = 0; i < 300; i++) begin
      a  = rand_operand();
      b  = rand_operand();
      sf = 2'($urandom_range(0, 3));
      exp_p = ref_mul(a, b, sf);
      do_op(a, b, sf, 1'b1, p, lat);
      $display("op %0d sf=%b a=%h b=%h -> %h lat=%0d", i, sf, a, b, p, lat);
      check("rand_prod", p, exp_p);
`ifndef YSYX_22040750_MUL_EARLY_EXIT_EN
      check("rand_lat", W2'(lat), W2'(LAT));
`else
      check("rand_lat_max", W2'(lat <= LAT), W2'(1));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
